enc8to3_q: RTL and testbench
============================

ENC8TO3_Q -- requirements
Module: enc8to3_q

Interface
REQ-001 Parameter: STICKY, 1, 1 = request bits held in pending register until encoded; 0 = pending register reloaded from d every cycle (unserved bits dropped).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 d  input  8  request lines; bit i high = request for code i; any number of bits may be high.
REQ-005 s  output  3  encoded index of the request held in the output slot.
REQ-006 valid  output  1  output slot holds a code; s meaningful only when high.
REQ-007 ready  input  1  consumer accepts s when valid and ready are both high at a rising edge.
REQ-008 pend  output  8  pending-request register, for observation.

Function
REQ-009 Internal state: pend[7:0], output slot (s, valid); with ENC8TO3_RR_EN, also pointer ptr[2:0].
REQ-010 The slot is loadable in a cycle when valid is low, or when valid and ready are both high.
REQ-011 Loadable and pend nonzero: slot loads the selected index k; valid becomes 1; pend bit k is cleared at the same edge.
REQ-012 Loadable and pend zero: valid becomes 0; s holds its previous value.
REQ-013 Not loadable (valid high, ready low): s, valid and ptr hold; s is stable for the whole stall.
REQ-014 STICKY=1: pend_next = (pend & ~clear_mask) | d; set wins, so a d bit equal to the bit being loaded re-pends it.
REQ-015 STICKY=0: pend_next = d; clear_mask is ignored.
REQ-016 Latency: a d bit sampled at edge N is in pend after N; with an empty, loadable slot, valid and s are visible after edge N+1.
REQ-017 Throughput: one code per cycle while ready stays high and pend stays nonzero.
REQ-018 pend = 0 and d = 0 for consecutive cycles: valid drains to 0 after the next accepted transfer.
REQ-019 d = 8'h00 never produces valid; no code is ever emitted twice for a single, non-reasserted request.

Reset
REQ-020 rst high at a rising edge: pend = 8'h00, s = 3'b000, valid = 0, ptr = 3'b000; d is ignored at that edge.
REQ-021 rst mid-stall discards the held code and all pending bits; no transfer completes at the reset edge, even if ready is high.
REQ-022 After rst deasserts, the first d is sampled at the next edge; timing follows REQ-016.

Configuration
REQ-023 Macro ENC8TO3_RR_EN.
REQ-024 Undefined: fixed priority; k = highest set index of pend (bit 7 highest); no ptr logic is present.
REQ-025 Defined: round-robin priority; k = first set bit of pend scanning upward from ptr, wrapping 7 to 0.
REQ-026 With the macro defined, ptr = (k+1) mod 8 on each load; ptr holds otherwise; k = 7 wraps ptr to 0.
REQ-027 Ports, latency and handshake are identical with and without the macro.

Verification
REQ-028 Reset, then d = 8'h00 for 5 cycles, ready = 1 -> valid = 0 throughout; pend = 8'h00; s = 0.
REQ-029 ready = 1 throughout.
- Fixed priority, STICKY=1: one-cycle pulse d = 8'h01, then 8'h02, then 8'h04 ... through 8'h80 (one bit per cycle).
- Required: s = 0,1,...,7 on consecutive cycles, each one cycle after its d pulse; the decoder testbench must round-trip each value.
REQ-030 Fixed priority, STICKY=1, ready = 1: one-cycle pulse d = 8'hA5 -> s sequence 7,5,2,0 on consecutive cycles, then valid = 0, pend = 8'h00.
REQ-031 Stall with d = 8'h18: ready = 0 for 4 cycles -> s = 4 held stable with valid = 1 and pend = 8'h08; ready = 1 -> s = 3 next cycle.
REQ-032 ENC8TO3_RR_EN defined, ready = 1: d = 8'h81 held continuously -> s = 0,7,0,7...; ptr alternates 1,0.
REQ-033 d = 8'hFF, ready = 0, 2 cycles, then rst for 1 cycle with ready = 1 -> no transfer at the reset edge; valid = 0, pend = 8'h00 after reset.

Source files
------------

// File: rtl/enc8to3_q.sv
// enc8to3_q: registered 8-to-3 request encoder with a valid/ready output slot.
//
// Request bits on d are collected in a pending register. Whenever the output
// slot is free (or is being accepted in the same cycle), one pending request
// is encoded into s and its pending bit is cleared.
//
// Build option: define ENC8TO3_RR_EN for round-robin selection; when it is
// left undefined, selection is fixed priority with bit 7 highest.
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  synchronous active-high reset
//   d      in   8  request lines, bit i requests code i
//   ready  in   1  consumer accepts s when valid & ready
//   s      out  3  encoded index held in the output slot
//   valid  out  1  output slot holds a code
//   pend   out  8  pending-request register (observation)
module enc8to3_q #(
  parameter bit STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d,
  input  logic       ready,
  output logic [2:0] s,
  output logic       valid,
  output logic [7:0] pend
);

  logic [7:0] pend_q, pend_d;
  logic [2:0] s_q, s_d;
  logic       valid_q, valid_d;
  logic       loadable;
  logic       do_load;
  logic [2:0] k;
  logic [7:0] clear_mask;

`ifdef ENC8TO3_RR_EN
  logic [2:0] ptr_q, ptr_d;

  // First set bit scanning upward from ptr; the 3-bit add wraps 7 -> 0.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    k     = 3'd0;
    found = 1'b0;
    idx   = 3'd0;
    for (int j = 0; j < 8; j++) begin
      idx = ptr_q + 3'(j);
      if (!found && pend_q[idx]) begin
        k     = idx;
        found = 1'b1;
      end
    end
  end
`else
  // Ascending scan with last hit winning gives the highest set index.
  always_comb begin
    k = 3'd0;
    for (int j = 0; j < 8; j++) begin
      if (pend_q[j]) k = 3'(j);
    end
  end
`endif

  assign loadable = !valid_q || ready;
  assign do_load  = loadable && (pend_q != 8'h00);

  always_comb begin
    clear_mask = 8'h00;
    s_d        = s_q;
    valid_d    = valid_q;
    if (loadable) begin
      valid_d = do_load;
      if (do_load) begin
        s_d           = k;
        clear_mask[k] = 1'b1;
      end
    end
    // Set wins over clear: a fresh request for the code being loaded re-pends.
    if (STICKY) pend_d = (pend_q & ~clear_mask) | d;
    else        pend_d = d;
  end

`ifdef ENC8TO3_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (do_load) ptr_d = k + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 3'd0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 8'h00;
      s_q     <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      s_q     <= s_d;
      valid_q <= valid_d;
    end
  end

  assign s     = s_q;
  assign valid = valid_q;
  assign pend  = pend_q;

endmodule

// File: tb/tb_enc8to3_q.sv
// Directed self-checking bench for enc8to3_q (STICKY=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_enc8to3_q;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       ready;
  logic [2:0] s;
  logic       valid;
  logic [7:0] pend;

  int total = 0;
  int bad   = 0;

  enc8to3_q #(.STICKY(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .ready (ready),
    .s     (s),
    .valid (valid),
    .pend  (pend)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    d     = 8'h00;
    ready = 1'b1;
    tick();
    tick();
    check_val("rst_pend", pend, 8'h00);
    check_val("rst_s", {5'd0, s}, 8'h00);
    check_val("rst_valid", {7'd0, valid}, 8'h00);
    rst = 1'b0;

    // Idle: no requests must never produce valid.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("idle_valid", {7'd0, valid}, 8'h00);
      check_val("idle_pend", pend, 8'h00);
      check_val("idle_s", {5'd0, s}, 8'h00);
    end

`ifndef ENC8TO3_RR_EN
    // Walking one-hot pulses: each code appears one cycle after its pulse.
    for (int i = 0; i < 8; i++) begin
      d = 8'h01 << i;
      tick();
      if (i > 0) begin
        check_val("walk_s", {5'd0, s}, 8'(i - 1));
        check_val("walk_valid", {7'd0, valid}, 8'h01);
        check_val("walk_dec", 8'h01 << s, 8'h01 << (i - 1));
      end
    end
    d = 8'h00;
    tick();
    check_val("walk_s7", {5'd0, s}, 8'h07);
    check_val("walk_valid7", {7'd0, valid}, 8'h01);
    tick();
    check_val("walk_drain", {7'd0, valid}, 8'h00);

    // Multi-bit pulse 0xA5 drains highest first: 7,5,2,0.
    d = 8'hA5;
    tick();
    check_val("a5_pend", pend, 8'hA5);
    d = 8'h00;
    tick(); check_val("a5_s7", {5'd0, s}, 8'h07); check_val("a5_p25", pend, 8'h25);
    tick(); check_val("a5_s5", {5'd0, s}, 8'h05); check_val("a5_p05", pend, 8'h05);
    tick(); check_val("a5_s2", {5'd0, s}, 8'h02); check_val("a5_p01", pend, 8'h01);
    tick(); check_val("a5_s0", {5'd0, s}, 8'h00); check_val("a5_v", {7'd0, valid}, 8'h01);
    tick();
    check_val("a5_drain_v", {7'd0, valid}, 8'h00);
    check_val("a5_drain_p", pend, 8'h00);
    check_val("a5_hold_s", {5'd0, s}, 8'h00);

    // Stall: code 4 held while ready is low, code 3 follows on release.
    ready = 1'b0;
    d = 8'h18;
    tick();
    d = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("stall_s", {5'd0, s}, 8'h04);
      check_val("stall_valid", {7'd0, valid}, 8'h01);
      check_val("stall_pend", pend, 8'h08);
    end
    ready = 1'b1;
    tick();
    check_val("stall_s3", {5'd0, s}, 8'h03);
    check_val("stall_p0", pend, 8'h00);
    tick();
    check_val("stall_drain", {7'd0, valid}, 8'h00);
`else
    // Round-robin: 0x81 held alternates 0,7 with ptr 1,0.
    d = 8'h81;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("rr_s", {5'd0, s}, (i % 2 == 0) ? 8'h00 : 8'h07);
      check_val("rr_ptr", {5'd0, dut.ptr_q}, (i % 2 == 0) ? 8'h01 : 8'h00);
      check_val("rr_valid", {7'd0, valid}, 8'h01);
    end
    d = 8'h00;
    do_reset();
`endif

    // Reset during a stall discards held code and pending bits.
    do_reset();
    d = 8'hFF;
    ready = 1'b0;
    tick();
    check_val("ff_pend", pend, 8'hFF);
    tick();
    check_val("ff_valid", {7'd0, valid}, 8'h01);
    check_val("ff_pend2", pend, 8'hFF);
    rst = 1'b1;
    ready = 1'b1;
    tick();
    check_val("ffrst_valid", {7'd0, valid}, 8'h00);
    check_val("ffrst_pend", pend, 8'h00);
    check_val("ffrst_s", {5'd0, s}, 8'h00);
    rst = 1'b0;
    d = 8'h00;
    tick();
    check_val("post_valid", {7'd0, valid}, 8'h00);
    check_val("post_pend", pend, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
